// File: rtl/noc_port_fifo_array_if.sv
// Handshake bundle for noc_port_fifo_array.
// Purpose : groups the per-port write, read, status and error signals of the
//           multi-channel input FIFO so they travel as one port.
// Signals : in_data/in_valid/in_full/in_afull  - write side, slice p = port p
//           out_data/out_valid/out_ready       - first-word-fall-through read side
//           count                              - per-port occupancy
//           ovf_err/udf_err/err_clr            - sticky error flags and their clear
// Modports: master = producer/consumer around the FIFO, slave = the FIFO array.
interface noc_port_fifo_array_if #(
  parameter int NUM_PORTS = 5,
  parameter int DATASIZE  = 40,
  parameter int DEPTH     = 16
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic [NUM_PORTS*DATASIZE-1:0] in_data;
  logic [NUM_PORTS-1:0]          in_valid;
  logic [NUM_PORTS-1:0]          in_full;
  logic [NUM_PORTS-1:0]          in_afull;
  logic [NUM_PORTS*DATASIZE-1:0] out_data;
  logic [NUM_PORTS-1:0]          out_valid;
  logic [NUM_PORTS-1:0]          out_ready;
  logic [NUM_PORTS*CW-1:0]       count;
  logic [NUM_PORTS-1:0]          ovf_err;
  logic [NUM_PORTS-1:0]          udf_err;
  logic                          err_clr;

  modport master (
    output in_data, in_valid, out_ready, err_clr,
    input  in_full, in_afull, out_data, out_valid, count, ovf_err, udf_err
  );

  modport slave (
    input  in_data, in_valid, out_ready, err_clr,
    output in_full, in_afull, out_data, out_valid, count, ovf_err, udf_err
  );
endinterface

// File: rtl/noc_port_fifo_array.sv
// noc_port_fifo_array
// Purpose : NUM_PORTS fully independent circular-buffer FIFOs, one per router
//           input channel, with first-word-fall-through read data.
// Ports   : clk   - router clock, all state changes on the rising edge
//           rst_n - asynchronous active-low reset (storage array is not reset)
//           bus   - noc_port_fifo_array_if.slave carrying the per-port
//                   write/read handshakes, occupancy and sticky error flags
// Status flags (full/afull/valid) are registers updated from the next
// occupancy, so they always equal a decode of the registered counter and
// have no combinational path from in_valid/out_ready.
module noc_port_fifo_array #(
  parameter int NUM_PORTS = 5,
  parameter int DATASIZE  = 40,
  parameter int DEPTH     = 16,
  parameter int AFULL_TH  = DEPTH - 2
) (
  input logic                  clk,
  input logic                  rst_n,
  noc_port_fifo_array_if.slave bus
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [AW-1:0] PTR_ONE   = AW'(1'b1);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1'b1);
  localparam logic [CW-1:0] CNT_ZERO  = {CW{1'b0}};
  localparam logic [CW-1:0] CNT_FULL  = CW'(DEPTH);
  localparam logic [CW-1:0] CNT_AFULL = CW'(AFULL_TH);

  logic [NUM_PORTS*DATASIZE-1:0] out_data_s;
  logic [NUM_PORTS-1:0]          in_full_s;
  logic [NUM_PORTS-1:0]          in_afull_s;
  logic [NUM_PORTS-1:0]          out_valid_s;
  logic [NUM_PORTS-1:0]          ovf_err_s;
  logic [NUM_PORTS-1:0]          udf_err_s;
  logic [NUM_PORTS*CW-1:0]       count_s;

  genvar p;
  generate
    for (p = 0; p < NUM_PORTS; p++) begin : g_port
      logic [DATASIZE-1:0] mem_r [DEPTH];
      logic [AW-1:0]       wptr_r;
      logic [AW-1:0]       rptr_r;
      logic [CW-1:0]       cnt_r;
      logic [CW-1:0]       cnt_nxt_s;
      logic                full_r;
      logic                afull_r;
      logic                valid_r;
      logic                ovf_r;
      logic                udf_r;
      logic                wr_s;
      logic                rd_s;
      logic                ovf_ev_s;
      logic                udf_ev_s;

      // Accept/reject decisions and next occupancy, gated by registered flags only
      always_comb begin
        wr_s     = bus.in_valid[p] & ~full_r;
        rd_s     = bus.out_ready[p] & valid_r;
        ovf_ev_s = bus.in_valid[p] & full_r;
        udf_ev_s = bus.out_ready[p] & ~valid_r;
        case ({wr_s, rd_s})
          2'b10:   cnt_nxt_s = cnt_r + CNT_ONE;
          2'b01:   cnt_nxt_s = cnt_r - CNT_ONE;
          default: cnt_nxt_s = cnt_r;
        endcase
      end

      // Flit storage; contents are meaningless until written, so no reset
      always_ff @(posedge clk) begin
        if (wr_s) begin
          mem_r[wptr_r] <= bus.in_data[p*DATASIZE +: DATASIZE];
        end
      end

      // Pointers, occupancy and the status flags decoded from next occupancy
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          wptr_r  <= {AW{1'b0}};
          rptr_r  <= {AW{1'b0}};
          cnt_r   <= CNT_ZERO;
          full_r  <= 1'b0;
          afull_r <= 1'b0;
          valid_r <= 1'b0;
        end else begin
          // DEPTH is a power of two, so natural pointer overflow is the wrap
          if (wr_s) begin
            wptr_r <= wptr_r + PTR_ONE;
          end
          if (rd_s) begin
            rptr_r <= rptr_r + PTR_ONE;
          end
          cnt_r   <= cnt_nxt_s;
          full_r  <= (cnt_nxt_s == CNT_FULL);
          afull_r <= (cnt_nxt_s >= CNT_AFULL);
          valid_r <= (cnt_nxt_s != CNT_ZERO);
        end
      end

      // Sticky error flags; a fresh event takes priority over err_clr
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          ovf_r <= 1'b0;
          udf_r <= 1'b0;
        end else begin
          if (ovf_ev_s) begin
            ovf_r <= 1'b1;
          end else if (bus.err_clr) begin
            ovf_r <= 1'b0;
          end
          if (udf_ev_s) begin
            udf_r <= 1'b1;
          end else if (bus.err_clr) begin
            udf_r <= 1'b0;
          end
        end
      end

      assign out_data_s[p*DATASIZE +: DATASIZE] = mem_r[rptr_r];
      assign count_s[p*CW +: CW]                = cnt_r;
      assign in_full_s[p]                       = full_r;
      assign in_afull_s[p]                      = afull_r;
      assign out_valid_s[p]                     = valid_r;
      assign ovf_err_s[p]                       = ovf_r;
      assign udf_err_s[p]                       = udf_r;
    end
  endgenerate

  assign bus.out_data  = out_data_s;
  assign bus.count     = count_s;
  assign bus.in_full   = in_full_s;
  assign bus.in_afull  = in_afull_s;
  assign bus.out_valid = out_valid_s;
  assign bus.ovf_err   = ovf_err_s;
  assign bus.udf_err   = udf_err_s;
endmodule

// File: tb/tb_noc_port_fifo_array.sv
// Testbench for noc_port_fifo_array (4 ports, 40-bit flits, depth 4, afull at 3).
// Directed table of cycle vectors with hand-derived expectations, reset
// sequences, then random traffic compared against a queue-based model.
module tb_noc_port_fifo_array;
  localparam int NP = 4;
  localparam int DW = 40;
  localparam int DP = 4;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  noc_port_fifo_array_if #(.NUM_PORTS(NP), .DATASIZE(DW), .DEPTH(DP)) bus ();

  noc_port_fifo_array #(
    .NUM_PORTS(NP), .DATASIZE(DW), .DEPTH(DP), .AFULL_TH(3)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  iv;
    logic [3:0]  ord;
    logic [39:0] d;
    logic        clr;
    logic [3:0]  ev;
    logic [3:0]  ef;
    logic [3:0]  ea;
    logic [3:0]  eo;
    logic [3:0]  eu;
    int          ep;
    logic [2:0]  ec;
    logic [39:0] eh;
  } vec_t;

  vec_t        tbl[$];
  logic [39:0] mq[NP][$];
  logic [3:0]  ovf_m;
  logic [3:0]  udf_m;

  function automatic vec_t mk(input logic [3:0] iv, input logic [3:0] ord,
                              input logic [39:0] d, input logic clr,
                              input logic [3:0] ev, input logic [3:0] ef,
                              input logic [3:0] ea, input logic [3:0] eo,
                              input logic [3:0] eu, input int ep,
                              input logic [2:0] ec, input logic [39:0] eh);
    vec_t v;
    v.iv = iv; v.ord = ord; v.d = d; v.clr = clr;
    v.ev = ev; v.ef = ef; v.ea = ea; v.eo = eo; v.eu = eu;
    v.ep = ep; v.ec = ec; v.eh = eh;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int p = 0; p < NP; p++) mq[p].delete();
    ovf_m = 4'b0000;
    udf_m = 4'b0000;
  endtask

  // Advance the reference model using the inputs about to be clocked in
  task automatic model_step();
    for (int p = 0; p < NP; p++) begin
      int sz;
      bit wr, rd, oe, ue;
      sz = mq[p].size();
      wr = bus.in_valid[p] && (sz < DP);
      rd = bus.out_ready[p] && (sz > 0);
      oe = bus.in_valid[p] && (sz == DP);
      ue = bus.out_ready[p] && (sz == 0);
      if (rd) void'(mq[p].pop_front());
      if (wr) mq[p].push_back(bus.in_data[p*DW +: DW]);
      if (oe) ovf_m[p] = 1'b1;
      else if (bus.err_clr) ovf_m[p] = 1'b0;
      if (ue) udf_m[p] = 1'b1;
      else if (bus.err_clr) udf_m[p] = 1'b0;
    end
  endtask

  task automatic cycle();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_model(input string tag);
    logic [3:0]  ev, ef, ea;
    logic [11:0] ec;
    for (int p = 0; p < NP; p++) begin
      ev[p] = mq[p].size() > 0;
      ef[p] = mq[p].size() == DP;
      ea[p] = mq[p].size() >= 3;
      ec[p*3 +: 3] = 3'(mq[p].size());
    end
    chk({tag, " valid"}, bus.out_valid, ev);
    chk({tag, " full"},  bus.in_full, ef);
    chk({tag, " afull"}, bus.in_afull, ea);
    chk({tag, " count"}, bus.count, ec);
    chk({tag, " ovf"},   bus.ovf_err, ovf_m);
    chk({tag, " udf"},   bus.udf_err, udf_m);
    for (int p = 0; p < NP; p++) begin
      if (ev[p]) chk($sformatf("%s head%0d", tag, p), bus.out_data[p*DW +: DW], mq[p][0]);
    end
  endtask

  task automatic idle();
    bus.in_valid  = 4'b0000;
    bus.out_ready = 4'b0000;
    bus.err_clr   = 1'b0;
    bus.in_data   = {(NP*DW){1'b0}};
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    checks   = 0;
    failures = 0;
    model_reset();
    idle();
    rst_n = 1'b0;

    // Directed table: {iv, ord, d, clr, exp valid, full, afull, ovf, udf, port, count, head}
    tbl.push_back(mk(4'b0100, 4'b0000, 40'hA1, 1'b0, 4'b0100, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 2, 3'd1, 40'hA1));
    tbl.push_back(mk(4'b0000, 4'b0100, 40'h00, 1'b0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 2, 3'd0, 40'h00));
    tbl.push_back(mk(4'b0001, 4'b0000, 40'h01, 1'b0, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 0, 3'd1, 40'h01));
    tbl.push_back(mk(4'b0001, 4'b0000, 40'h02, 1'b0, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 0, 3'd2, 40'h01));
    tbl.push_back(mk(4'b0001, 4'b0000, 40'h03, 1'b0, 4'b0001, 4'b0000, 4'b0001, 4'b0000, 4'b0000, 0, 3'd3, 40'h01));
    tbl.push_back(mk(4'b0001, 4'b0000, 40'h04, 1'b0, 4'b0001, 4'b0001, 4'b0001, 4'b0000, 4'b0000, 0, 3'd4, 40'h01));
    tbl.push_back(mk(4'b0001, 4'b0000, 40'h05, 1'b0, 4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0000, 0, 3'd4, 40'h01));
    tbl.push_back(mk(4'b0000, 4'b0001, 40'h00, 1'b0, 4'b0001, 4'b0000, 4'b0001, 4'b0001, 4'b0000, 0, 3'd3, 40'h02));
    tbl.push_back(mk(4'b0000, 4'b0001, 40'h00, 1'b0, 4'b0001, 4'b0000, 4'b0000, 4'b0001, 4'b0000, 0, 3'd2, 40'h03));
    tbl.push_back(mk(4'b0000, 4'b0001, 40'h00, 1'b0, 4'b0001, 4'b0000, 4'b0000, 4'b0001, 4'b0000, 0, 3'd1, 40'h04));
    tbl.push_back(mk(4'b0000, 4'b0001, 40'h00, 1'b0, 4'b0000, 4'b0000, 4'b0000, 4'b0001, 4'b0000, 0, 3'd0, 40'h00));
    tbl.push_back(mk(4'b0000, 4'b0000, 40'h00, 1'b1, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 0, 3'd0, 40'h00));
    tbl.push_back(mk(4'b0000, 4'b0001, 40'h00, 1'b0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0001, 0, 3'd0, 40'h00));
    tbl.push_back(mk(4'b0000, 4'b0000, 40'h00, 1'b1, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 0, 3'd0, 40'h00));
    tbl.push_back(mk(4'b0000, 4'b0001, 40'h00, 1'b1, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0001, 0, 3'd0, 40'h00));
    tbl.push_back(mk(4'b0000, 4'b0000, 40'h00, 1'b1, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 0, 3'd0, 40'h00));
    tbl.push_back(mk(4'b0001, 4'b0001, 40'h77, 1'b0, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 4'b0001, 0, 3'd1, 40'h77));
    tbl.push_back(mk(4'b0000, 4'b0001, 40'h00, 1'b1, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 0, 3'd0, 40'h00));
    tbl.push_back(mk(4'b0010, 4'b0000, 40'hE0, 1'b0, 4'b0010, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1, 3'd1, 40'hE0));
    tbl.push_back(mk(4'b0010, 4'b0000, 40'hE1, 1'b0, 4'b0010, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1, 3'd2, 40'hE0));
    for (int k = 0; k < 6; k++) begin
      logic [39:0] hd;
      hd = (k == 0) ? 40'hE1 : (40'h10 + 40'(k - 1));
      tbl.push_back(mk(4'b0010, 4'b0010, 40'h10 + 40'(k), 1'b0, 4'b0010, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1, 3'd2, hd));
    end
    tbl.push_back(mk(4'b0000, 4'b0010, 40'h00, 1'b0, 4'b0010, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1, 3'd1, 40'h15));
    tbl.push_back(mk(4'b0000, 4'b0010, 40'h00, 1'b0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1, 3'd0, 40'h00));
    tbl.push_back(mk(4'b1000, 4'b0000, 40'h31, 1'b0, 4'b1000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 3, 3'd1, 40'h31));
    tbl.push_back(mk(4'b1000, 4'b0000, 40'h32, 1'b0, 4'b1000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 3, 3'd2, 40'h31));
    tbl.push_back(mk(4'b1000, 4'b0000, 40'h33, 1'b0, 4'b1000, 4'b0000, 4'b1000, 4'b0000, 4'b0000, 3, 3'd3, 40'h31));
    tbl.push_back(mk(4'b1000, 4'b0000, 40'h34, 1'b0, 4'b1000, 4'b1000, 4'b1000, 4'b0000, 4'b0000, 3, 3'd4, 40'h31));
    tbl.push_back(mk(4'b1000, 4'b1000, 40'h35, 1'b0, 4'b1000, 4'b0000, 4'b1000, 4'b1000, 4'b0000, 3, 3'd3, 40'h32));
    tbl.push_back(mk(4'b0000, 4'b1000, 40'h00, 1'b0, 4'b1000, 4'b0000, 4'b0000, 4'b1000, 4'b0000, 3, 3'd2, 40'h33));
    tbl.push_back(mk(4'b0000, 4'b1000, 40'h00, 1'b0, 4'b1000, 4'b0000, 4'b0000, 4'b1000, 4'b0000, 3, 3'd1, 40'h34));
    tbl.push_back(mk(4'b0000, 4'b1000, 40'h00, 1'b0, 4'b0000, 4'b0000, 4'b0000, 4'b1000, 4'b0000, 3, 3'd0, 40'h00));
    tbl.push_back(mk(4'b0000, 4'b0000, 40'h00, 1'b1, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 3, 3'd0, 40'h00));

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("reset valid", bus.out_valid, 64'h0);
    chk("reset full", bus.in_full, 64'h0);
    chk("reset afull", bus.in_afull, 64'h0);
    chk("reset count", bus.count, 64'h0);
    chk("reset errs", {bus.ovf_err, bus.udf_err}, 64'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Directed vectors
    foreach (tbl[i]) begin
      bus.in_valid  = tbl[i].iv;
      bus.out_ready = tbl[i].ord;
      bus.in_data   = {NP{tbl[i].d}};
      bus.err_clr   = tbl[i].clr;
      cycle();
      chk($sformatf("t%0d valid", i), bus.out_valid, tbl[i].ev);
      chk($sformatf("t%0d full", i),  bus.in_full, tbl[i].ef);
      chk($sformatf("t%0d afull", i), bus.in_afull, tbl[i].ea);
      chk($sformatf("t%0d ovf", i),   bus.ovf_err, tbl[i].eo);
      chk($sformatf("t%0d udf", i),   bus.udf_err, tbl[i].eu);
      chk($sformatf("t%0d count", i), bus.count[tbl[i].ep*3 +: 3], tbl[i].ec);
      if (tbl[i].ev[tbl[i].ep])
        chk($sformatf("t%0d head", i), bus.out_data[tbl[i].ep*DW +: DW], tbl[i].eh);
      check_model($sformatf("t%0d", i));
    end
    idle();

    // Mid-cycle reset with port 0 holding three flits
    for (int k = 0; k < 3; k++) begin
      bus.in_valid = 4'b0001;
      bus.in_data  = {NP{40'hC0 + 40'(k)}};
      cycle();
    end
    idle();
    check_model("prerst");
    #2;
    rst_n = 1'b0;
    #1;
    chk("async rst valid", bus.out_valid, 64'h0);
    chk("async rst count", bus.count, 64'h0);
    chk("async rst afull", bus.in_afull, 64'h0);
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    bus.in_valid = 4'b0001;
    bus.in_data  = {NP{40'hD5}};
    cycle();
    idle();
    chk("post rst count", bus.count[2:0], 64'h1);
    chk("post rst head", bus.out_data[DW-1:0], 64'hD5);
    check_model("postrst");

    // Random traffic against the queue model, alternating fill/drain bias
    for (int i = 0; i < 600; i++) begin
      int wp;
      wp = ((i / 40) % 2 == 0) ? 75 : 25;
      for (int p = 0; p < NP; p++) begin
        bus.in_valid[p]         = ($urandom_range(99) < wp);
        bus.out_ready[p]        = ($urandom_range(99) >= wp);
        bus.in_data[p*DW +: DW] = {8'($urandom), 32'($urandom)};
      end
      bus.err_clr = ($urandom_range(15) == 0);
      cycle();
      check_model($sformatf("rnd%0d", i));
    end
    idle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/noc_port_fifo_array.md
NOC_PORT_FIFO_ARRAY -- requirements
Module: noc_port_fifo_array

Interface
REQ-001 Parameter NUM_PORTS, default 5: number of independent input channels (port p occupies slice p of every flattened bus).
REQ-002 Parameter DATASIZE, default 40: flit width in bits.
REQ-003 Parameter DEPTH, default 16: entries per channel; power of two, at least 2.
REQ-004 Parameter AFULL_TH, default DEPTH-2: occupancy at or above which in_afull[p] asserts; legal range 1..DEPTH.
REQ-005 Port clk, input, 1: single router clock; all state updates on the rising edge.
REQ-006 Port rst_n, input, 1: reset, asynchronous and active-low.
REQ-007 Port in_data, input, NUM_PORTS*DATASIZE: write flits, port p at bits [p*DATASIZE +: DATASIZE].
REQ-008 Port in_valid, input, NUM_PORTS: write request per port.
REQ-009 Port in_full, output, NUM_PORTS: channel holds DEPTH entries.
REQ-010 Port in_afull, output, NUM_PORTS: occupancy >= AFULL_TH.
REQ-011 Port out_data, input-side FWFT data, output, NUM_PORTS*DATASIZE: head flit per port.
REQ-012 Port out_valid, output, NUM_PORTS: channel non-empty; out_data slice valid.
REQ-013 Port out_ready, input, NUM_PORTS: consumer pops head this cycle.
REQ-014 Port count, output, NUM_PORTS*($clog2(DEPTH)+1): per-port occupancy.
REQ-015 Port ovf_err, output, NUM_PORTS: sticky overflow flag (write attempted while full).
REQ-016 Port udf_err, output, NUM_PORTS: sticky underflow flag (pop attempted while empty).
REQ-017 Port err_clr, input, 1: synchronous clear of all ovf_err/udf_err bits.

Function
REQ-018 Each port SHALL be an independent circular buffer: write pointer, read pointer, occupancy counter of width $clog2(DEPTH)+1; no coupling between ports.
REQ-019 Write accepted iff in_valid[p]=1 and in_full[p]=0 at the clock edge; data stored at write pointer, pointer increments modulo DEPTH.
REQ-020 Pop accepted iff out_ready[p]=1 and out_valid[p]=1; read pointer increments modulo DEPTH.
REQ-021 Output SHALL be first-word-fall-through: out_data[p] equals the entry at read pointer combinationally from storage; out_valid[p]=1 exactly one cycle after the first accepted write into an empty channel.
REQ-022 in_full, in_afull, out_valid SHALL be derived from the registered occupancy counter only (no combinational path from in_valid/out_ready).
REQ-023 Simultaneous accepted write and pop: occupancy unchanged, both pointers advance.
REQ-024 Write while full is dropped even if a pop occurs the same cycle; ovf_err[p] sets on the next edge.
REQ-025 Pop while empty is ignored (no pointer change); udf_err[p] sets on the next edge; a write in the same cycle is still accepted.
REQ-026 Pointer wrap from DEPTH-1 to 0 SHALL preserve FIFO order across the wrap.
REQ-027 err_clr=1 clears all error bits; if a new error event coincides with err_clr, the set wins.
REQ-028 Flit order per port SHALL be strictly preserved; no flit lost unless dropped per REQ-024.

Reset
REQ-029 On rst_n=0, asynchronously: all pointers and counters 0, out_valid=0, in_full=0, in_afull=0 (AFULL_TH>=1), count=0, ovf_err=0, udf_err=0.
REQ-030 Storage array is not reset; out_data is don't-care while out_valid=0.
REQ-031 Reset asserted mid-operation discards all buffered flits; first write after rst_n deassertion behaves as into an empty channel.

Verification (NUM_PORTS=4, DATASIZE=40, DEPTH=4, AFULL_TH=3)
REQ-032 Write 0xA1 on port 2 in one cycle, out_ready=0 -> next cycle out_valid=4'b0100, out_data[2]=0xA1, count[2]=1, other ports unaffected.
REQ-033 Write 0x1,0x2,0x3,0x4 back-to-back on port 0 -> in_afull[0]=1 after 3rd, in_full[0]=1 after 4th; 5th write 0x5 dropped, ovf_err[0]=1; pops return 0x1..0x4 in order.
REQ-034 Fill port 1 to 2, then 6 cycles of simultaneous write (0x10..0x15) and pop -> count[1] stays 2, outputs in order across pointer wrap.
REQ-035 Full port 3 with in_valid=1 and out_ready=1 same cycle -> head popped, write dropped, count[3]=3, ovf_err[3]=1.
REQ-036 out_ready[0]=1 while empty -> udf_err[0]=1 next cycle; err_clr pulse -> 0; error with coincident err_clr -> stays 1.
REQ-037 Port 0 holding 3 flits, rst_n pulsed low mid-cycle -> out_valid, count, in_afull drop to 0 immediately, before the next clock edge.
